siso_shift_sequencer: RTL and testbench

//   Sequencer for the serial-in/serial-out shift datapath. Accepts a parallel word over
//   a valid/ready handshake, drives it bit-serially through a DEPTH-stage SISO delay line
//   at a programmable bit rate, and tags each output bit with a valid flag.

---
 rtl/siso_shift_sequencer_pkg.sv | 19 +
 rtl/siso_delay_line.sv | 43 ++++
 rtl/siso_shift_sequencer.sv | 127 ++++++++++++
 tb/tb_siso_shift_sequencer.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/siso_shift_sequencer_pkg.sv
// rtl/siso_shift_sequencer_pkg.sv - shared state encodings, default sizes and counter sizing helper
package siso_shift_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_DEPTH  = 4;
    localparam int DEF_DIV_W  = 8;

    // Bits needed to count 0..max_count-1, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/siso_delay_line.sv
// rtl/siso_delay_line.sv - enable-gated SISO chain carrying a data bit and its valid tag
module siso_delay_line #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic in_bit,
    input  logic in_tag,
    output logic out_bit,
    output logic out_tag
);

    logic [DEPTH-1:0] bit_q, bit_d;
    logic [DEPTH-1:0] tag_q, tag_d;

    always_comb begin
        bit_d = bit_q;
        tag_d = tag_q;
        if (en) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                bit_d[i] = bit_q[i-1];
                tag_d[i] = tag_q[i-1];
            end
            bit_d[0] = in_bit;
            tag_d[0] = in_tag;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            bit_q <= '0;
            tag_q <= '0;
        end else begin
            bit_q <= bit_d;
            tag_q <= tag_d;
        end
    end

    assign out_bit = bit_q[DEPTH-1];
    assign out_tag = tag_q[DEPTH-1];

endmodule

// File: rtl/siso_shift_sequencer.sv
// rtl/siso_shift_sequencer.sv - frame FSM, bit-rate divider and bit counter driving the SISO delay line
module siso_shift_sequencer
    import siso_shift_sequencer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic              cfg_msb_first,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              sout,
    output logic              sout_valid,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = cnt_width((DATA_W > DEPTH) ? DATA_W : DEPTH);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] LAST_FLUSH = CNT_W'(DEPTH - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DIV_W-1:0]    div_lat_q, div_lat_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic                msb_q, msb_d;
    logic                done_q, done_d;
    logic                tick;
    logic                push_bit;
    logic                push_tag;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        div_lat_d = div_lat_q;
        div_cnt_d = div_cnt_q;
        bit_cnt_d = bit_cnt_q;
        msb_d     = msb_q;
        done_d    = 1'b0;
        push_bit  = 1'b0;
        push_tag  = 1'b0;
        tick      = (state_q != ST_IDLE) && (div_cnt_q == div_lat_q);

        if (state_q != ST_IDLE) begin
            div_cnt_d = tick ? '0 : div_cnt_q + DIV_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    data_d    = s_data;
                    div_lat_d = cfg_div;
                    msb_d     = cfg_msb_first;
                    div_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The latched word is consumed from the end facing the chosen bit order.
                push_bit = msb_q ? data_q[DATA_W-1] : data_q[0];
                push_tag = 1'b1;
                if (tick) begin
                    data_d = msb_q ? (data_q << 1) : (data_q >> 1);
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = ST_FLUSH;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_FLUSH) begin
                        bit_cnt_d = '0;
                        state_d   = ST_IDLE;
                        done_d    = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            data_q    <= '0;
            div_lat_q <= '0;
            div_cnt_q <= '0;
            bit_cnt_q <= '0;
            msb_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            div_lat_q <= div_lat_d;
            div_cnt_q <= div_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            msb_q     <= msb_d;
            done_q    <= done_d;
        end
    end

    siso_delay_line #(.DEPTH(DEPTH)) u_line (
        .clk     (clk),
        .clr_n   (rst),
        .en      (tick),
        .in_bit  (push_bit),
        .in_tag  (push_tag),
        .out_bit (sout),
        .out_tag (sout_valid)
    );

    assign s_ready = (state_q == ST_IDLE);
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_siso_shift_sequencer.sv
// tb/tb_siso_shift_sequencer.sv - directed self-checking bench for siso_shift_sequencer
module tb_siso_shift_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] cfg_div;
    logic       cfg_msb_first;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] s_data;
    logic       sout;
    logic       sout_valid;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    int          first_v;
    int          n_v;
    logic [63:0] bits;
    int          done_at;
    int          n_done;

    siso_shift_sequencer #(.DATA_W(8), .DEPTH(4), .DIV_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_div       (cfg_div),
        .cfg_msb_first (cfg_msb_first),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .sout          (sout),
        .sout_valid    (sout_valid),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input logic [7:0] word, input logic [7:0] div, input logic msb);
        s_data        = word;
        cfg_div       = div;
        cfg_msb_first = msb;
        s_valid       = 1'b1;
        step();
        s_valid       = 1'b0;
    endtask

    // Cycle c is sampled just after edge E(c) counted from the last accept edge.
    task automatic watch(input int max_cyc, output int fv, output int nv,
                         output logic [63:0] bv, output int da);
        fv = -1;
        nv = 0;
        bv = '0;
        da = -1;
        for (int c = 1; c <= max_cyc; c++) begin
            step();
            if (sout_valid) begin
                if (fv < 0) fv = c;
                nv++;
                bv = {bv[62:0], sout};
            end
            if (done) begin
                da = c;
                break;
            end
        end
    endtask

    initial begin
        rst           = 1'b0;
        cfg_div       = 8'd0;
        cfg_msb_first = 1'b1;
        s_valid       = 1'b0;
        s_data        = 8'h00;
        step();
        check("rst_sout", sout, 0);
        check("rst_valid", sout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ready", s_ready, 1);
        step();
        rst = 1'b1;
        step();

        // A5, div 0, MSB first
        accept(8'hA5, 8'd0, 1'b1);
        check("t2_busy", busy, 1);
        check("t2_ready", s_ready, 0);
        watch(40, first_v, n_v, bits, done_at);
        check("t2_first", first_v, 4);
        check("t2_nvalid", n_v, 8);
        check("t2_bits", bits, 64'hA5);
        check("t2_done_at", done_at, 12);
        step();
        check("t2_done_once", done, 0);
        check("t2_idle", busy, 0);

        // 01, div 2, LSB first: each bit held three clocks
        accept(8'h01, 8'd2, 1'b0);
        watch(80, first_v, n_v, bits, done_at);
        check("t3_first", first_v, 12);
        check("t3_nvalid", n_v, 24);
        check("t3_bits", bits, 64'hE00000);
        check("t3_done_at", done_at, 36);
        step();
        check("t3_done_once", done, 0);

        // Back-to-back: second word held off until the done cycle
        accept(8'h3C, 8'd0, 1'b1);
        s_data  = 8'hC3;
        s_valid = 1'b1;
        check("t4_ready_busy", s_ready, 0);
        watch(40, first_v, n_v, bits, done_at);
        check("t4a_bits", bits, 64'h3C);
        check("t4a_done_at", done_at, 12);
        check("t4_ready_done", s_ready, 1);
        step();
        s_valid = 1'b0;
        check("t4_busy2", busy, 1);
        check("t4_done_clr", done, 0);
        watch(40, first_v, n_v, bits, done_at);
        check("t4b_first", first_v, 4);
        check("t4b_nvalid", n_v, 8);
        check("t4b_bits", bits, 64'hC3);
        check("t4b_done_at", done_at, 12);
        step();

        // Reset after three output bits
        accept(8'hA5, 8'd0, 1'b1);
        repeat (6) step();
        check("t5_valid_pre", sout_valid, 1);
        #2 rst = 1'b0;
        #1;
        check("t5_sout", sout, 0);
        check("t5_valid", sout_valid, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", s_ready, 1);
        check("t5_done", done, 0);
        step();
        step();
        rst = 1'b1;
        n_done = 0;
        for (int c = 0; c < 14; c++) begin
            step();
            if (done) n_done++;
        end
        check("t5_no_done", n_done, 0);
        accept(8'hFF, 8'd0, 1'b1);
        watch(40, first_v, n_v, bits, done_at);
        check("t5_first", first_v, 4);
        check("t5_nvalid", n_v, 8);
        check("t5_bits", bits, 64'hFF);
        check("t5_done_at", done_at, 12);
        step();

        // Config change mid-frame only affects the next frame
        accept(8'h80, 8'd0, 1'b1);
        step();
        step();
        cfg_div       = 8'd5;
        cfg_msb_first = 1'b0;
        watch(40, first_v, n_v, bits, done_at);
        check("t6a_first", first_v, 2);
        check("t6a_nvalid", n_v, 8);
        check("t6a_bits", bits, 64'h80);
        check("t6a_done_at", done_at, 10);
        step();
        accept(8'h80, 8'd5, 1'b0);
        watch(120, first_v, n_v, bits, done_at);
        check("t6b_first", first_v, 24);
        check("t6b_nvalid", n_v, 48);
        check("t6b_bits", bits, 64'h3F);
        check("t6b_done_at", done_at, 72);
        step();
        check("t6b_done_once", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
